// File: rtl/trigger_pkg.sv
// Shared widths, evt_data field layout and the packed event record for the trigger event buffer.
package trigger_pkg;

  localparam int TRG_TYPE_W     = 5;
  localparam int TRG_POS_W      = 4;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_TS_WIDTH   = 32;
  localparam int DEF_DEPTH_LOG2 = 4;

  // Field offsets inside evt_data at default widths; timestamp occupies the LSBs.
  localparam int EVT_TS_LSB   = 0;
  localparam int EVT_NUM_LSB  = EVT_TS_LSB + DEF_TS_WIDTH;
  localparam int EVT_POS_LSB  = EVT_NUM_LSB + DEF_CNT_WIDTH;
  localparam int EVT_TYPE_LSB = EVT_POS_LSB + TRG_POS_W;
  localparam int EVT_W        = EVT_TYPE_LSB + TRG_TYPE_W;

  typedef struct packed {
    logic [TRG_TYPE_W-1:0]    trg_type;
    logic [TRG_POS_W-1:0]     trg_pos;
    logic [DEF_CNT_WIDTH-1:0] trg_num;
    logic [DEF_TS_WIDTH-1:0]  timestamp;
  } evt_t;

  function automatic int evt_width(input int cnt_w, input int ts_w);
    return TRG_TYPE_W + TRG_POS_W + cnt_w + ts_w;
  endfunction

endpackage

// File: rtl/trigger_event_buffer_if.sv
// Valid/ready event stream from the trigger event buffer to the readout stage.
interface trigger_event_buffer_if
  import trigger_pkg::*;
#(
  parameter int DATA_W = EVT_W
) ();

  logic [DATA_W-1:0] evt_data;
  logic              evt_valid;
  logic              evt_ready;

  modport master (output evt_data, output evt_valid, input evt_ready);
  modport slave  (input evt_data, input evt_valid, output evt_ready);

endinterface

// File: rtl/trigger_event_buffer_fifo.sv
// evt_fifo_sync: show-ahead synchronous FIFO; a push into a full FIFO is taken only alongside a pop.
module evt_fifo_sync #(
  parameter int WIDTH      = 57,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk80,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   fill
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (fill == '0);
  assign full    = (fill == FULL_LVL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk80) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Occupancy is the single source of truth; pointers just wrap.
  always_ff @(posedge clk80) begin
    if (reset | clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/trigger_event_buffer.sv
// Tags sampled triggers with trigger number and timestamp and queues them for readout.
// Optional dead-time veto is enabled with TRG_DEADTIME_EN.
module trigger_event_buffer
  import trigger_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int TS_WIDTH   = DEF_TS_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk80,
  input  logic                  reset,
  input  logic                  sync,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [TRG_TYPE_W-1:0] trigger_in,
  input  logic [TRG_POS_W-1:0]  trigger_pos,
`ifdef TRG_DEADTIME_EN
  input  logic [7:0]            deadtime,
  output logic [7:0]            veto_cnt,
`endif
  trigger_event_buffer_if.master evt_if,
  output logic [DEPTH_LOG2:0]   fill,
  output logic                  overflow,
  output logic [7:0]            drop_cnt
);

  localparam int DATA_W = evt_width(CNT_WIDTH, TS_WIDTH);

  logic                 flush;
  logic [TS_WIDTH-1:0]  timestamp;
  logic [CNT_WIDTH-1:0] trg_num;
  logic                 raw_evt;
  logic                 veto;
  logic                 det;
  logic                 drop;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 evt_valid_int;
  logic [DATA_W-1:0]    fifo_wr_data;
  logic [DATA_W-1:0]    fifo_rd_data;

  assign flush   = reset | clear;
  assign raw_evt = sync & enable & (trigger_in != '0);
  assign det     = raw_evt & ~veto;

  // Valid is masked during a flush so no handshake can complete on queued data being discarded.
  assign evt_valid_int    = ~fifo_empty & ~flush;
  assign pop              = evt_valid_int & evt_if.evt_ready;
  assign drop             = det & fifo_full & ~pop;
  assign evt_if.evt_valid = evt_valid_int;
  assign evt_if.evt_data  = evt_valid_int ? fifo_rd_data : '0;
  assign fifo_wr_data     = {trigger_in, trigger_pos, trg_num, timestamp};

  always_ff @(posedge clk80) begin
    if (flush) begin
      timestamp <= '0;
      trg_num   <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (sync) timestamp <= timestamp + 1'b1;
      if (det)  trg_num   <= trg_num + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

`ifdef TRG_DEADTIME_EN
  logic [7:0] dt_cnt;

  assign veto = raw_evt & (dt_cnt != '0);

  // Dead time restarts on every tagged event, dropped or not, and counts down in sync ticks.
  always_ff @(posedge clk80) begin
    if (flush) begin
      dt_cnt   <= '0;
      veto_cnt <= '0;
    end else begin
      if (det)                          dt_cnt <= deadtime;
      else if (sync && dt_cnt != '0)    dt_cnt <= dt_cnt - 1'b1;
      if (veto && veto_cnt != 8'hFF)    veto_cnt <= veto_cnt + 1'b1;
    end
  end
`else
  assign veto = 1'b0;
`endif

  evt_fifo_sync #(
    .WIDTH      (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk80   (clk80),
    .reset   (reset),
    .clear   (clear),
    .push    (det),
    .pop     (pop),
    .wr_data (fifo_wr_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .fill    (fill)
  );

endmodule

// File: tb/tb_trigger_event_buffer.sv
// Directed bench for trigger_event_buffer with a queue scoreboard of expected event words.
module tb_trigger_event_buffer;
  import trigger_pkg::*;

  logic                  clk80;
  logic                  reset;
  logic                  sync;
  logic                  enable;
  logic                  clear;
  logic [TRG_TYPE_W-1:0] trigger_in;
  logic [TRG_POS_W-1:0]  trigger_pos;
  logic [4:0]            fill;
  logic                  overflow;
  logic [7:0]            drop_cnt;
  logic [7:0]            deadtime;
  logic [7:0]            veto_cnt;

  trigger_event_buffer_if #(.DATA_W(EVT_W)) evt_if ();

  trigger_event_buffer dut (
    .clk80       (clk80),
    .reset       (reset),
    .sync        (sync),
    .enable      (enable),
    .clear       (clear),
    .trigger_in  (trigger_in),
    .trigger_pos (trigger_pos),
`ifdef TRG_DEADTIME_EN
    .deadtime    (deadtime),
    .veto_cnt    (veto_cnt),
`endif
    .evt_if      (evt_if),
    .fill        (fill),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

`ifndef TRG_DEADTIME_EN
  assign veto_cnt = 8'h00;
`endif

  always #5 clk80 = ~clk80;

  int checks = 0;
  int errors = 0;

  logic [EVT_W-1:0] q[$];
  logic [15:0]      m_trg;
  logic [31:0]      m_ts;
  logic             m_ovf;
  logic [7:0]       m_drop;
  logic [7:0]       m_dt;
  logic [7:0]       m_veto;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update the scoreboard from the inputs present before the edge.
  task automatic applyStimulus();
    evt_t w;
    logic raw, vet, det, do_pop;
    if (reset || clear) begin
      q.delete();
      m_ts = '0; m_trg = '0; m_ovf = 1'b0; m_drop = '0; m_dt = '0; m_veto = '0;
    end else begin
      do_pop = (q.size() != 0) && evt_if.evt_ready;
      if (do_pop) begin
        chk("pop.data", 64'(evt_if.evt_data), 64'(q[0]));
        void'(q.pop_front());
      end
      raw = sync && enable && (trigger_in != '0);
`ifdef TRG_DEADTIME_EN
      vet = raw && (m_dt != '0);
`else
      vet = 1'b0;
`endif
      det = raw && !vet;
      if (det) begin
        w.trg_type = trigger_in; w.trg_pos = trigger_pos; w.trg_num = m_trg; w.timestamp = m_ts;
        if (q.size() < 16) q.push_back(w);
        else begin
          m_ovf = 1'b1;
          if (m_drop != 8'hFF) m_drop++;
        end
        m_trg++;
        m_dt = deadtime;
      end else if (sync && m_dt != '0) m_dt--;
      if (vet && m_veto != 8'hFF) m_veto++;
      if (sync) m_ts++;
    end
    @(posedge clk80);
    #1;
    sync = ~sync;
  endtask

  task automatic checkOutput(input string tag);
    logic exp_valid;
    exp_valid = (q.size() != 0) && !reset && !clear;
    chk({tag, ".valid"}, 64'(evt_if.evt_valid), 64'(exp_valid));
    chk({tag, ".data"}, 64'(evt_if.evt_data), exp_valid ? 64'(q[0]) : 64'd0);
    chk({tag, ".fill"}, 64'(fill), 64'(q.size()));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".drop"}, 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic inject(input logic [4:0] t, input logic [3:0] p, input logic rdy);
    for (int g = 0; g < 4 && !sync; g++) applyStimulus();
    trigger_in = t; trigger_pos = p; evt_if.evt_ready = rdy;
    applyStimulus();
    trigger_in = '0; trigger_pos = '0; evt_if.evt_ready = 1'b0;
  endtask

  task automatic pulseClear();
    evt_if.evt_ready = 1'b0;
    clear = 1'b1;
    applyStimulus();
    clear = 1'b0;
  endtask

  initial begin
    logic [EVT_W-1:0] exp_word;
    clk80 = 1'b0; reset = 1'b1; clear = 1'b0; sync = 1'b0; enable = 1'b1;
    trigger_in = '0; trigger_pos = '0; evt_if.evt_ready = 1'b0; deadtime = 8'd0;
    q.delete(); m_ts = '0; m_trg = '0; m_ovf = 1'b0; m_drop = '0; m_dt = '0; m_veto = '0;
    #2;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    checkOutput("reset");

    // First event tagged with timestamp 100 and trigger number 0.
    for (int g = 0; g < 1000 && !(sync && m_ts == 32'd100); g++) applyStimulus();
    inject(5'b00010, 4'd7, 1'b0);
    exp_word = {5'b00010, 4'd7, 16'd0, 32'd100};
    chk("first.valid", 64'(evt_if.evt_valid), 64'd1);
    chk("first.data", 64'(evt_if.evt_data), 64'(exp_word));
    evt_if.evt_ready = 1'b1;
    applyStimulus();
    evt_if.evt_ready = 1'b0;
    chk("first.fill", 64'(fill), 64'd0);
    checkOutput("first.after");

    // Overflow: 18 triggers into a stalled 16-deep FIFO.
    pulseClear();
    for (int i = 0; i < 18; i++) inject(5'd3, 4'(i), 1'b0);
    chk("ovf.fill", 64'(fill), 64'd16);
    chk("ovf.flag", 64'(overflow), 64'd1);
    chk("ovf.drop", 64'(drop_cnt), 64'd2);
    checkOutput("ovf");

    // Full FIFO with simultaneous pop accepts the new event.
    inject(5'd9, 4'd1, 1'b1);
    chk("fullpop.fill", 64'(fill), 64'd16);
    chk("fullpop.drop", 64'(drop_cnt), 64'd2);

    evt_if.evt_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("drain.num", 64'(evt_if.evt_data[EVT_NUM_LSB +: 16]), 64'(i));
      applyStimulus();
    end
    chk("drain.last", 64'(evt_if.evt_data[EVT_NUM_LSB +: 16]), 64'd18);
    applyStimulus();
    evt_if.evt_ready = 1'b0;
    checkOutput("drained");

    // Triggers off a sync cycle or with enable low are ignored.
    for (int g = 0; g < 4 && sync; g++) applyStimulus();
    trigger_in = 5'd3;
    applyStimulus();
    for (int g = 0; g < 4 && !sync; g++) applyStimulus();
    enable = 1'b0;
    applyStimulus();
    enable = 1'b1; trigger_in = '0;
    chk("ignored.fill", 64'(fill), 64'd0);
    checkOutput("ignored");
    inject(5'd4, 4'd1, 1'b0);
    chk("ignored.num", 64'(evt_if.evt_data[EVT_NUM_LSB +: 16]), 64'd19);

    // drop_cnt saturates at 255.
    pulseClear();
    for (int i = 0; i < 276; i++) inject(5'd1, 4'd2, 1'b0);
    chk("sat.drop", 64'(drop_cnt), 64'd255);
    checkOutput("sat");

    // Clear with five events queued and three drops.
    pulseClear();
    for (int i = 0; i < 19; i++) inject(5'd6, 4'd3, 1'b0);
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 11; i++) applyStimulus();
    evt_if.evt_ready = 1'b0;
    chk("preclr.fill", 64'(fill), 64'd5);
    chk("preclr.drop", 64'(drop_cnt), 64'd3);
    pulseClear();
    chk("clr.fill", 64'(fill), 64'd0);
    chk("clr.valid", 64'(evt_if.evt_valid), 64'd0);
    chk("clr.ovf", 64'(overflow), 64'd0);
    chk("clr.drop", 64'(drop_cnt), 64'd0);
    inject(5'd1, 4'd0, 1'b0);
    exp_word = {5'd1, 4'd0, 16'd0, 32'd0};
    chk("clr.ts", 64'(evt_if.evt_data), 64'(exp_word));
    checkOutput("clr.after");

`ifdef TRG_DEADTIME_EN
    // Dead time of 4 sync ticks vetoes the next four consecutive triggers.
    pulseClear();
    deadtime = 8'd4;
    for (int g = 0; g < 4 && !sync; g++) applyStimulus();
    trigger_in = 5'd5;
    for (int i = 0; i < 12; i++) applyStimulus();
    trigger_in = '0;
    chk("dt.veto", 64'(veto_cnt), 64'd4);
    chk("dt.veto_model", 64'(veto_cnt), 64'(m_veto));
    chk("dt.fill", 64'(fill), 64'd2);
    evt_if.evt_ready = 1'b1;
    chk("dt.num0", 64'(evt_if.evt_data[EVT_NUM_LSB +: 16]), 64'd0);
    applyStimulus();
    chk("dt.num1", 64'(evt_if.evt_data[EVT_NUM_LSB +: 16]), 64'd1);
    applyStimulus();
    evt_if.evt_ready = 1'b0;
    checkOutput("dt");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_event_buffer.md
Name: trigger_event_buffer

Overview:
- Sits directly downstream of the asynchronous trigger sampler, in the clk80 domain.
- Takes each 40 MHz-qualified trigger (5-bit type, 4-bit sub-clock position) and tags it with a running trigger number and a timestamp.
- Queues tagged events in a synchronous FIFO for the readout/DAQ stage, using a valid/ready handshake.
- Flags and counts events lost to FIFO overflow.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 entries (default 16).
- TS_WIDTH, 32: timestamp counter width, in 40 MHz ticks.
- CNT_WIDTH, 16: trigger number width.

Ports:
- clk80  in  1  system clock, 80 MHz
- reset  in  1  synchronous, active-high reset
- sync  in  1  40 MHz enable; high on every second clk80 cycle
- enable  in  1  trigger acceptance enable
- clear  in  1  synchronous soft clear; same effect as reset
- trigger_in  in  5  trigger type from sampler; nonzero means event
- trigger_pos  in  4  sub-clock position from sampler
- evt_data  out  9+CNT_WIDTH+TS_WIDTH  {trigger_in, trigger_pos, trg_num, timestamp}, MSB first (57 bits at default)
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- fill  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
- overflow  out  1  sticky; set on first dropped event
- drop_cnt  out  8  dropped events, saturating at 255

Behaviour:
- Clocking and reset:
  - Single clock clk80. Reset is synchronous and active-high.
  - reset or clear (in the same cycle) zeroes: FIFO pointers, fill, evt_valid, evt_data, overflow, drop_cnt, trg_num, timestamp.
  - A clear or reset mid-readout discards every queued event. No handshake completes in that cycle.
- Timestamp:
  - Increments by 1 in each cycle with sync=1, independent of enable.
  - Wraps modulo 2**TS_WIDTH.
- Detection:
  - event = sync & enable & (trigger_in != 0).
  - trigger_in and trigger_pos are sampled only when sync=1; other cycles are ignored.
- Tagging:
  - The stored word uses the timestamp and trg_num values present before their increment in the detection cycle.
  - trg_num increments on every detected event, accepted or dropped, so gaps in trg_num reveal losses.
  - trg_num wraps modulo 2**CNT_WIDTH.
- Write:
  - The event is written in the detection cycle if the FIFO is not full, or if it is full and a pop happens in the same cycle (a simultaneous pop frees the slot).
  - Otherwise the event is dropped: overflow <= 1, and drop_cnt increments unless it is already 255.
- Read:
  - Show-ahead FIFO. pop = evt_valid & evt_ready.
  - evt_valid goes high in the cycle after the write into an empty FIFO; write-to-valid latency is 1 cycle.
  - While evt_valid=0, evt_data is forced to 0. evt_data is stable while evt_valid=1 and evt_ready=0.
- fill:
  - Registered; updates in the cycle after each push/pop.
  - Simultaneous push and pop leave fill unchanged.
  - Pointers are DEPTH_LOG2 bits and wrap naturally. Full and empty are decoded from fill.
- evt_ready is ignored while evt_valid=0.

Optional Feature:
- Macro: TRG_DEADTIME_EN.
- When defined:
  - Adds input port deadtime (8 bits, in sync ticks) and output veto_cnt (8 bits, saturating).
  - After an accepted-or-dropped event, a down-counter is loaded with deadtime and decrements on sync.
  - While the counter is nonzero, detections are vetoed: not written, trg_num not incremented, veto_cnt incremented.
  - deadtime=0 disables the veto.
  - reset and clear zero both the counter and veto_cnt.
- When undefined: neither port exists and no veto is applied.

Decomposition:
- Package trigger_pkg holds:
  - widths TRG_TYPE_W=5 and TRG_POS_W=4;
  - default CNT_WIDTH/TS_WIDTH;
  - evt_data field offsets, plus a packed event struct typedef.
- One sub-module, evt_fifo_sync: parameterised width/depth storage with push, pop, full, empty and fill, using the same reset/clear semantics.

Test Plan:
- After reset, pulse trigger_in=5'b00010, pos=4'd7 on a sync cycle with timestamp=100 -> next cycle evt_valid=1 and evt_data={00010,0111,trg_num=0,ts=100}. With evt_ready=1, fill returns to 0.
- Hold evt_ready=0 and inject 18 triggers -> fill=16, overflow=1, drop_cnt=2. Draining shows trg_num 0..15 in order; trg_num 16 and 17 are never read.
- With the FIFO full, inject a trigger while evt_ready=1 -> event accepted, fill stays 16, drop_cnt unchanged.
- Assert trigger_in nonzero on a non-sync cycle, or with enable=0 -> no write, trg_num unchanged.
- Assert clear with 5 events queued and drop_cnt=3 -> next cycle: fill=0, evt_valid=0, overflow=0, drop_cnt=0, timestamp=0.
- With TRG_DEADTIME_EN and deadtime=4, triggers on consecutive sync ticks -> first accepted, next 4 vetoed (veto_cnt=4), sixth accepted with trg_num=1.
